add_sub_seq: RTL



---
 rtl/add_sub_seq_if.sv | 27 ++
 rtl/add_sub_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/add_sub_seq_if.sv
// Operand/result handshake bundle for the chunked adder/subtractor.
// The master drives operands and accepts results. The slave is the arithmetic block.
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, operand_a, operand_b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, operand_a, operand_b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB chunk first, through a registered carry.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  add_sub_seq_if.slave bus
);
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk [NCH];
  logic [CHUNK-1:0] b_chunk [NCH];
  logic [CHUNK:0]   chunk_res;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             chunk_ovf;
  logic [WIDTH-1:0] sum_upd;

  // Slice the latched operands into chunks; each result chunk only takes the adder output on its own cycle.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
      assign sum_upd[gi*CHUNK +: CHUNK] =
        (cnt_q == CNT_W'(gi)) ? chunk_s : sum_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_res = {1'b0, a_chunk[cnt_q]} + {1'b0, b_chunk[cnt_q]} + {{CHUNK{1'b0}}, carry_q};
  assign chunk_s   = chunk_res[CHUNK-1:0];
  assign chunk_c   = chunk_res[CHUNK];
  // b_q already holds the inverted operand for subtraction, so one rule covers both modes.
  assign chunk_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_s[CHUNK-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.operand_a;
          b_d     = bus.sub ? ~bus.operand_b : bus.operand_b;
          carry_d = bus.sub;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_upd;
        carry_d = chunk_c;
        if (cnt_q == LAST_CNT) begin
          cout_d  = chunk_c;
          ovf_d   = chunk_ovf;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule
